// File: rtl/key_event_module.sv
// key_event_module
// Classifies a debounced key level into single-cycle event pulses:
// short click, double click, long press and (optionally) auto-repeat.
// Contains its own millisecond timebase derived from the clock.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   -> Repeat_Pulse fires every REPEAT_MS while held after a long press
//   undefined -> repeat logic removed, Repeat_Pulse tied to 0
//
// Ports:
//   CLOCK        in   sole clock, rising edge
//   RST          in   synchronous active-high reset
//   Key_Level    in   debounced key level, 1 = pressed
//   Short_Pulse  out  one-cycle pulse for a single short click
//   Double_Pulse out  one-cycle pulse for a double click
//   Long_Pulse   out  one-cycle pulse when the hold reaches LONG_MS
//   Repeat_Pulse out  one-cycle pulse every REPEAT_MS during a long hold
//   Busy         out  high whenever the classifier is not idle
module key_event_module #(
  parameter logic [15:0] T1MS      = 16'd49_999,
  parameter logic [15:0] LONG_MS   = 16'd1000,
  parameter logic [15:0] DCLICK_MS = 16'd250,
  parameter logic [15:0] REPEAT_MS = 16'd100
) (
  input  logic CLOCK,
  input  logic RST,
  input  logic Key_Level,
  output logic Short_Pulse,
  output logic Double_Pulse,
  output logic Long_Pulse,
  output logic Repeat_Pulse,
  output logic Busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] count1;
  logic [15:0] count_ms;
  logic        tb_clear;
  logic        short_nxt, double_nxt, long_nxt;
`ifdef KEY_REPEAT_EN
  logic        repeat_nxt;
`endif

  // Next-state and pulse decision. A level change is tested before the
  // timeout in every state so that it wins when both occur at one edge.
  always_comb begin
    state_nxt  = state;
    tb_clear   = 1'b0;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
`ifdef KEY_REPEAT_EN
    repeat_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (Key_Level) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (!Key_Level) begin
          state_nxt = WAIT2;
        end else if (count_ms == LONG_MS) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end
      end
      WAIT2: begin
        if (Key_Level) begin
          state_nxt = PRESS2;
        end else if (count_ms == DCLICK_MS) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end
      end
      PRESS2: begin
        if (!Key_Level) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end else if (count_ms == LONG_MS) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end
      end
      HOLD: begin
        if (!Key_Level) begin
          state_nxt = IDLE;
        end
`ifdef KEY_REPEAT_EN
        else if (count_ms == REPEAT_MS) begin
          // Restart the timebase so the next repeat is a full period away.
          repeat_nxt = 1'b1;
          tb_clear   = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    // Every state change starts timing afresh.
    if (state_nxt != state) tb_clear = 1'b1;
  end

  // State and registered pulses
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state        <= IDLE;
      Short_Pulse  <= 1'b0;
      Double_Pulse <= 1'b0;
      Long_Pulse   <= 1'b0;
    end else begin
      state        <= state_nxt;
      Short_Pulse  <= short_nxt;
      Double_Pulse <= double_nxt;
      Long_Pulse   <= long_nxt;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge CLOCK) begin
    if (RST) Repeat_Pulse <= 1'b0;
    else     Repeat_Pulse <= repeat_nxt;
  end
`else
  assign Repeat_Pulse = 1'b0;
`endif

  // Millisecond timebase: count1 wraps every T1MS+1 cycles, count_ms
  // counts wraps and saturates so long idle/hold periods never alias.
  always_ff @(posedge CLOCK) begin
    if (RST || tb_clear) begin
      count1   <= 16'd0;
      count_ms <= 16'd0;
    end else if (count1 == T1MS) begin
      count1 <= 16'd0;
      if (count_ms != 16'hFFFF) count_ms <= count_ms + 16'd1;
    end else begin
      count1 <= count1 + 16'd1;
    end
  end

  assign Busy = (state != IDLE);

endmodule
